simd_stream_loader: RTL and testbench

- Programmable strided read engine that sits directly upstream of the SIMD lane datapath and downstream of a lane's scratch RAM.
- Once started, it issues `count` reads at base, base+stride, base+2·stride, …
- It absorbs the RAM's fixed 1-cycle registered read latency.
- It delivers each word on a valid/ready stream, with full-rate throughput and backpressure handled by an internal FIFO.

---
 rtl/simd_stream_pkg.sv | 18 +
 rtl/simd_sync_fifo.sv | 65 ++++++
 rtl/simd_stream_loader.sv | 127 ++++++++++++
 tb/tb_simd_stream_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/simd_stream_pkg.sv
// Shared types and sizing helpers for the SIMD strided stream loader.
package simd_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
   localparam int unsigned FIFO_PTR_W         = $clog2(FIFO_DEPTH_DEFAULT);

   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/simd_sync_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of 2 (>= 2).
// Push on full and pop on empty are dropped and flagged by assertion.
module simd_sync_fifo
   import simd_stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = fifo_ptr_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
   assign count     = cnt_q;
   assign head_data = mem_q[rd_ptr_q];
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + (PTR_W+1)'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: validity is tracked entirely by the counter.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/simd_stream_loader.sv
// Strided RAM read engine: start in cycle s, first read s+1, first out_valid s+3, one word/cycle.
// Reads are only issued against free FIFO credit, so out_ready backpressure never loses data.
module simd_stream_loader
   import simd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 16,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_start,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [ADDR_WIDTH-1:0] cfg_stride,
   input  logic [CNT_WIDTH-1:0]  cfg_count,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_read_req,
   output logic [ADDR_WIDTH-1:0] mem_read_addr,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready
);

   localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
   logic                  inflight_q;

   logic [PTR_W:0]        fifo_count;
   logic [PTR_W+1:0]      occupancy;
   logic                  fifo_empty, fifo_full;
   logic                  pop;

   // Credit uses pre-pop occupancy plus the word still in the RAM pipeline.
   assign occupancy     = {1'b0, fifo_count} + (PTR_W+2)'(inflight_q);
   assign mem_read_req  = (state_q == RUN) && (issue_cnt_q < count_q)
                          && (occupancy < (PTR_W+2)'(FIFO_DEPTH));
   assign mem_read_addr = addr_q;

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign out_last  = out_valid && (pop_cnt_q == count_q - CNT_WIDTH'(1));
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      count_d     = count_q;
      issue_cnt_d = issue_cnt_q;
      pop_cnt_d   = pop ? pop_cnt_q + CNT_WIDTH'(1) : pop_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               addr_d      = cfg_base;
               stride_d    = cfg_stride;
               count_d     = cfg_count;
               issue_cnt_d = '0;
               pop_cnt_d   = '0;
               state_d     = (cfg_count != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (mem_read_req) begin
               addr_d      = addr_q + stride_q;
               issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
               if (issue_cnt_q + CNT_WIDTH'(1) == count_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop_cnt_d == count_q) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         count_q     <= '0;
         issue_cnt_q <= '0;
         pop_cnt_q   <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         count_q     <= count_d;
         issue_cnt_q <= issue_cnt_d;
         pop_cnt_q   <= pop_cnt_d;
         inflight_q  <= mem_read_req;
      end
   end

   simd_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (mem_read_data),
      .pop       (pop),
      .head_data (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   a_credit_holds: assert property (@(posedge clk) disable iff (reset) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_simd_stream_loader.sv
// Directed bench for simd_stream_loader: scripted streams checked against a cycle model.
module tb_simd_stream_loader;

   logic        clk;
   logic        reset;
   logic        cfg_start;
   logic [9:0]  cfg_base;
   logic [9:0]  cfg_stride;
   logic [15:0] cfg_count;
   logic        busy, done;
   logic        mem_read_req;
   logic [9:0]  mem_read_addr;
   logic [31:0] mem_read_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;

   logic [31:0] ram [1024];
   int          checks = 0;
   int          errors = 0;

   simd_stream_loader dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_start     (cfg_start),
      .cfg_base      (cfg_base),
      .cfg_stride    (cfg_stride),
      .cfg_count     (cfg_count),
      .busy          (busy),
      .done          (done),
      .mem_read_req  (mem_read_req),
      .mem_read_addr (mem_read_addr),
      .mem_read_data (mem_read_data),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_last      (out_last),
      .out_ready     (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read RAM: data appears the cycle after the strobe and holds otherwise.
   always @(posedge clk) begin
      if (mem_read_req) mem_read_data <= ram[mem_read_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: out_ready high; mode 1: sparse random ready with a 10-cycle stall.
   // inj_cycle > 0 pulses a conflicting start then; rst_pops > 0 resets after that many pops.
   task automatic run_stream(input logic [9:0] base, input logic [9:0] stride,
                             input logic [15:0] count, input int mode,
                             input int inj_cycle, input int rst_pops);
      logic [9:0]  nxt;
      logic [9:0]  q[$];
      logic [31:0] prev_data;
      int          m_occ, m_infl, issued, pops, c;
      bit          last_pop_prev, stalled_prev, done_seen, exp_done, popped;
      nxt = base; m_occ = 0; m_infl = 0; issued = 0; pops = 0;
      last_pop_prev = 0; stalled_prev = 0; done_seen = 0; prev_data = '0;
      cfg_base = base; cfg_stride = stride; cfg_count = count; cfg_start = 1'b1;
      out_ready = 1'b1;
      tick();
      cfg_start = 1'b0;
      c = 1;
      while (!done_seen && c < 400) begin
         if (mode == 0) out_ready = 1'b1;
         else if (c >= 8 && c < 18) out_ready = 1'b0;
         else out_ready = ($urandom_range(0, 9) < 3);
         if (c == inj_cycle) begin
            cfg_start = 1'b1; cfg_base = 10'd700; cfg_stride = 10'd2; cfg_count = 16'd9;
         end else begin
            cfg_start = 1'b0;
         end
         exp_done = (count == 0 && c == 1) || last_pop_prev;
         chk("done", done, exp_done);
         chk("busy", busy, 1);
         if (c == 1 && count != 0) chk("first_req_latency", mem_read_req, 1);
         chk("valid", out_valid, m_occ != 0);
         if (out_valid && stalled_prev) chk("stall_stable", out_data, prev_data);
         if (mem_read_req) begin
            chk("addr", mem_read_addr, nxt);
            chk("credit", (m_occ + m_infl) < 4, 1);
            chk("no_extra_issue", issued < int'(count), 1);
            q.push_back(nxt);
            nxt = nxt + stride;
            issued++;
         end
         popped = 0;
         if (out_valid && q.size() > 0) begin
            chk("data", out_data, 32'(100 + int'(q[0])));
            chk("last", out_last, pops == int'(count) - 1);
            if (out_ready) begin
               void'(q.pop_front());
               pops++;
               popped = 1;
            end
         end
         last_pop_prev = popped && (pops == int'(count));
         stalled_prev  = out_valid && !out_ready;
         prev_data     = out_data;
         if (done) done_seen = 1;
         m_occ  = m_occ + m_infl - (popped ? 1 : 0);
         m_infl = mem_read_req ? 1 : 0;
         if (rst_pops > 0 && pops == rst_pops) begin
            reset = 1'b1;
            tick();
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req", mem_read_req, 0);
            chk("rst_last", out_last, 0);
            reset = 1'b0;
            return;
         end
         tick();
         c++;
      end
      cfg_start = 1'b0;
      chk("done_seen", done_seen, 1);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_valid", out_valid, 0);
      chk("issued_total", issued, 32'(count));
      chk("popped_total", pops, 32'(count));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'(100 + i);
      reset = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_count = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_req", mem_read_req, 0);
      chk("reset_addr", mem_read_addr, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_last", out_last, 0);
      reset = 1'b0;
      tick();

      run_stream(10'd0, 10'd1, 16'd8, 0, 0, 0);       // basic stream 100..107
      run_stream(10'd1020, 10'd3, 16'd4, 0, 0, 0);    // wrap: 1020,1023,2,5
      run_stream(10'd10, 10'h3FE, 16'd6, 0, 0, 0);    // negative stride
      run_stream(10'd200, 10'd1, 16'd16, 1, 0, 0);    // backpressure
      run_stream(10'd5, 10'd1, 16'd0, 0, 0, 0);       // empty job
      run_stream(10'd40, 10'd1, 16'd6, 0, 3, 0);      // start while busy ignored
      run_stream(10'd300, 10'd1, 16'd10, 0, 0, 3);    // reset mid-stream
      run_stream(10'd500, 10'd5, 16'd2, 0, 0, 0);     // fresh job after reset

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
